// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and tag type for the multiplier scheduler
package mult_pkg;
  localparam int WIDTH_DEF  = 8;
  localparam int PROD_W_DEF = 2 * WIDTH_DEF;
  localparam int NREQ_MAX   = 8;
  // id is sized for the largest supported NREQ so one tag type serves every build
  localparam int ID_W       = $clog2(NREQ_MAX);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    int idx;
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - shares one pipelined multiplier among NREQ requesters
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_p,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  busy
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gid;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic            accept;
  logic [NREQ-1:0] rsp_onehot;
  tag_t            pipe [0:LAT];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .id  (gid),
    .any (any)
  );

  // grant is masked during reset so nothing can be accepted on the release edge
  assign req_ready = rst ? '0 : gnt;
  assign accept    = any & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      ptr   <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
      mul_a <= req_a[gid*WIDTH +: WIDTH];
      mul_b <= req_b[gid*WIDTH +: WIDTH];
    end
  end

  // stage 0 aligns with mul_a/mul_b; stage LAT aligns with a valid mul_p
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{vld: accept, id: gid};
      for (int s = 1; s <= LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NREQ; i++) rsp_onehot[i] = (int'(pipe[LAT].id) == i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (pipe[LAT].vld) begin
      rsp_valid <= rsp_onehot;
      rsp_data  <= mul_p;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_comb begin
    busy = |rsp_valid;
    for (int s = 0; s <= LAT; s++) busy = busy | pipe[s].vld;
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - directed and fairness bench for mult_rr_scheduler
module tb_mult_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic [2*WIDTH-1:0]    mul_p, p1, p2;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  busy;

  int n_total = 0;
  int n_pass  = 0;

  mult_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // two-stage model multiplier
  always @(posedge clk) begin
    p1 <= {8'b0, mul_a} * {8'b0, mul_b};
    p2 <= p1;
  end
  assign mul_p = p2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic single(input int i, input int a, input int b);
    req_valid     = '0;
    req_valid[i]  = 1'b1;
    set_ops(i, a, b);
    tick();
    req_valid = '0;
  endtask

  logic [NREQ-1:0] v;
  logic [NREQ-1:0] g;
  int              wait_cnt [NREQ];

  initial begin
    // reset state
    #2;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single request from requester 0
    req_valid = 4'b0001;
    set_ops(0, 10, 5);
    #1;
    check_eq("t2_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check_eq("t2_mul_a", mul_a, 10);
    check_eq("t2_busy", busy, 1);
    check_eq("t2_rv_k0", rsp_valid, 0);
    tick();
    check_eq("t2_rv_k1", rsp_valid, 0);
    tick();
    check_eq("t2_rv_k2", rsp_valid, 0);
    tick();
    check_eq("t2_rv_k3", rsp_valid, 4'b0001);
    check_eq("t2_data", rsp_data, 50);
    tick();
    check_eq("t2_rv_after", rsp_valid, 0);
    check_eq("t2_busy_idle", busy, 0);

    // back-to-back from requester 1 (ptr now 1)
    req_valid = 4'b0010;
    set_ops(1, 100, 7);
    #1;
    check_eq("t3_ready", req_ready, 4'b0010);
    tick();
    set_ops(1, 200, 200);
    #1;
    check_eq("t3_ready2", req_ready, 4'b0010);
    tick();
    set_ops(1, 99, 10);
    tick();
    req_valid = '0;
    tick();
    check_eq("t3_rv0", rsp_valid, 4'b0010);
    check_eq("t3_d0", rsp_data, 700);
    tick();
    check_eq("t3_rv1", rsp_valid, 4'b0010);
    check_eq("t3_d1", rsp_data, 40000);
    tick();
    check_eq("t3_rv2", rsp_valid, 4'b0010);
    check_eq("t3_d2", rsp_data, 990);
    drain();

    // ptr is 2; a grant to 3 wraps it to 0
    single(2, 1, 2);
    single(3, 3, 3);
    drain();

    // all four valid at once
    set_ops(0, 88, 99);
    set_ops(1, 255, 255);
    set_ops(2, 0, 77);
    set_ops(3, 1, 1);
    req_valid = 4'b1111;
    #1;
    check_eq("t4_g0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1110;
    #1;
    check_eq("t4_g1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1100;
    #1;
    check_eq("t4_g2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1000;
    #1;
    check_eq("t4_g3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    check_eq("t4_rv0", rsp_valid, 4'b0001);
    check_eq("t4_d0", rsp_data, 8712);
    tick();
    check_eq("t4_rv1", rsp_valid, 4'b0010);
    check_eq("t4_d1", rsp_data, 65025);
    tick();
    check_eq("t4_rv2", rsp_valid, 4'b0100);
    check_eq("t4_d2", rsp_data, 0);
    tick();
    check_eq("t4_rv3", rsp_valid, 4'b1000);
    check_eq("t4_d3", rsp_data, 1);
    drain();

    // fairness: ptr 0 -> grant 2 leaves ptr at 3
    single(2, 2, 2);
    req_valid = 4'b1001;
    #1;
    check_eq("t5_first", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    #1;
    check_eq("t5_second", req_ready, 4'b0001);
    tick();
    drain();

    v = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      req_valid = v;
      #1;
      g = req_ready;
      check_eq("t5_onehot", (g & ~v) == '0 && $countones(g) == (v != '0 ? 1 : 0), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          check_eq("t5_starve", wait_cnt[i] <= NREQ - 1, 1);
          wait_cnt[i] = 0;
          v[i]        = 1'b0;
        end else if (v[i]) begin
          if (g != '0) wait_cnt[i]++;
        end
      end
      tick();
    end
    drain();

    // reset with three operations in flight, leaving ptr at 3
    req_valid = 4'b0001;
    set_ops(0, 11, 11);
    tick();
    req_valid = 4'b0010;
    set_ops(1, 12, 12);
    tick();
    req_valid = 4'b0100;
    set_ops(2, 13, 13);
    tick();
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_ready_rst", req_ready, 0);
    check_eq("t6_busy_rst", busy, 0);
    check_eq("t6_mul_a_rst", mul_a, 0);
    check_eq("t6_rv_rst", rsp_valid, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t6_no_rsp", rsp_valid, 0);
    end
    check_eq("t6_busy", busy, 0);
    req_valid = 4'b1111;
    #1;
    check_eq("t6_ptr0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
